// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end: state encoding
// and the legal word-width range.
package ser_pkg;

    // Narrowest and widest word the serializer is built for
    localparam int SER_WIDTH_MIN = 2;
    localparam int SER_WIDTH_MAX = 32;

    // Shifter FSM: IDLE means the shifter holds no live word
    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // True when a requested word width can be built
    function automatic bit ser_width_legal(input int width);
        return (width >= SER_WIDTH_MIN) && (width <= SER_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake plus serial output bundle of the bit serializer.
// The master side supplies words and the stall request; the slave side
// (the serializer) answers with ready and the serial stream.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             stall;
    logic             ser_bit;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output word_in,
        output word_valid,
        output stall,
        input  word_ready,
        input  ser_bit,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  word_in,
        input  word_valid,
        input  stall,
        output word_ready,
        output ser_bit,
        output ser_valid,
        output word_done,
        output busy
    );

endinterface

// File: rtl/bit_serializer_hold_reg.sv
// One-entry valid/ready holding register. It accepts a word whenever it is
// empty and releases it when the shifter FSM strobes i_take. Ready depends
// only on the registered full flag, so nothing downstream can reach it
// combinationally.
module ser_hold_reg
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_take,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    // Ready is simply "empty"; take and accept can never coincide because
    // take needs a full register while accept needs an empty one
    assign o_ready  = ~r_full;
    assign w_accept = i_valid & ~r_full;
    assign o_full   = r_full;
    assign o_data   = r_data;

    // Capture a word on a handshake, drop it when the shifter takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the bit-stream detectors. Words enter
// through a one-word holding register and leave one bit per non-stalled
// clock; when the holding register is already full at the last bit of a
// word, the next word is loaded on the same edge so the stream is gapless.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    bit_serializer_if.slave  bus
);

    localparam int            CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    // Refuse to elaborate widths the counter and shifter are not sized for
    if (!ser_width_legal(WIDTH)) begin : g_badWidth
        $error("bit_serializer: WIDTH must lie in 2..32");
    end

    ser_state_t       r_state;
    ser_state_t       w_nextState;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bitCnt;

    logic             w_holdFull;
    logic [WIDTH-1:0] w_holdData;
    logic             w_wordReady;
    logic             w_take;
    logic             w_serValid;
    logic             w_lastBit;
    logic             w_wordDone;
    logic             w_advance;
    logic             w_load;

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (bus.word_in),
        .i_valid (bus.word_valid),
        .o_ready (w_wordReady),
        .i_take  (w_take),
        .o_full  (w_holdFull),
        .o_data  (w_holdData)
    );

    // State register; reset abandons any word in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: start when a held word exists and the output is not
    // paused, fall back to idle only when the last bit leaves with nothing
    // waiting behind it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SER_IDLE: begin
                if (w_holdFull && !bus.stall) begin
                    w_nextState = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (w_wordDone && !w_holdFull) begin
                    w_nextState = SER_IDLE;
                end
            end
            default: begin
                w_nextState = SER_IDLE;
            end
        endcase
    end

    // Output and datapath strobes: a bit is live whenever the shifter is
    // loaded and not paused; the load strobe doubles as the hold take
    always_comb begin
        w_serValid = (r_state == SER_SHIFT) && !bus.stall;
        w_lastBit  = (r_bitCnt == '0);
        w_wordDone = w_serValid && w_lastBit;
        w_advance  = w_serValid && !w_lastBit;
        w_load     = ((r_state == SER_IDLE) && w_holdFull && !bus.stall)
                   || (w_wordDone && w_holdFull);
        w_take     = w_load;
    end

    // Shifter and bit counter: load from hold, step toward the output end,
    // and clear once the last bit has left so idle output reads zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (w_load) begin
            r_shift  <= w_holdData;
            r_bitCnt <= CNT_TOP;
        end else if (w_advance) begin
            r_shift  <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};
            r_bitCnt <= r_bitCnt - 1'b1;
        end else if (w_wordDone) begin
            r_shift  <= '0;
        end
    end

    assign bus.word_ready = w_wordReady;
    assign bus.ser_bit    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign bus.ser_valid  = w_serValid;
    assign bus.word_done  = w_wordDone;
    assign bus.busy       = w_holdFull | (r_state == SER_SHIFT);

endmodule
